// File: rtl/bit_population_counter_pipe_if.sv
// Valid/ready bus for bit_population_counter_pipe: beat in, population count out.
interface bit_population_counter_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             data_val_i;
  logic [WIDTH-1:0] data_i;
  logic             mode_i;
  logic             data_ready_o;
  logic             data_val_o;
  logic [CW-1:0]    data_o;
  logic             data_ready_i;

  modport master (
    output data_val_i, data_i, mode_i, data_ready_i,
    input  data_ready_o, data_val_o, data_o
  );

  modport slave (
    input  data_val_i, data_i, mode_i, data_ready_i,
    output data_ready_o, data_val_o, data_o
  );
endinterface

// File: rtl/bit_population_counter_pipe.sv
// Pipelined population counter: registered CHUNK-bit leaves feeding a registered
// binary adder tree, with a single global stall driven by output backpressure.
module bit_population_counter_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic                            clk_i,
  input  logic                            srst_i,
  bit_population_counter_pipe_if.slave    bus
);
  localparam int unsigned NLEAF  = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned DEPTH  = $clog2(NLEAF);
  localparam int unsigned LEAVES = 1 << DEPTH;
  localparam int unsigned LW     = $clog2(CHUNK + 1);
  localparam int unsigned CW     = $clog2(WIDTH + 1);

  logic                      w_adv;
  logic                      w_vout;
  logic [CW-1:0]             w_sum;
  logic [LEAVES*CHUNK-1:0]   w_op;

  function automatic logic [LW-1:0] leaf_count(input logic [CHUNK-1:0] b);
    logic [LW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < CHUNK; i++) c = c + LW'(b[i]);
    return c;
  endfunction

  // Inversion is applied to the real bits only; pad bits stay 0 in both modes.
  always_comb begin
    w_op            = '0;
    w_op[WIDTH-1:0] = bus.mode_i ? ~bus.data_i : bus.data_i;
  end

  // Level 0 holds the leaf counts; level l holds LEAVES>>l sums of width LW+l.
  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    logic [LW+l-1:0] r_s [LEAVES>>l];
    logic            r_v;

    if (l == 0) begin : g_leaf
      always_ff @(posedge clk_i) begin
        if (!srst_i)    r_v <= 1'b0;
        else if (w_adv) r_v <= bus.data_val_i;
      end

      always_ff @(posedge clk_i) begin
        if (w_adv) begin
          for (int unsigned n = 0; n < LEAVES; n++)
            r_s[n] <= leaf_count(w_op[n*CHUNK +: CHUNK]);
        end
      end
    end else begin : g_add
      always_ff @(posedge clk_i) begin
        if (!srst_i)    r_v <= 1'b0;
        else if (w_adv) r_v <= g_lvl[l-1].r_v;
      end

      always_ff @(posedge clk_i) begin
        if (w_adv) begin
          for (int unsigned n = 0; n < (LEAVES >> l); n++)
            r_s[n] <= {1'b0, g_lvl[l-1].r_s[2*n]} + {1'b0, g_lvl[l-1].r_s[2*n+1]};
        end
      end
    end
  end

  // Final sum never exceeds WIDTH, so resizing to CW loses nothing.
  assign w_sum  = CW'(g_lvl[DEPTH].r_s[0]);
  assign w_vout = g_lvl[DEPTH].r_v;
  assign w_adv  = !w_vout || bus.data_ready_i;

  assign bus.data_ready_o = w_adv;
  assign bus.data_val_o   = w_vout;
  assign bus.data_o       = w_vout ? w_sum : '0;
endmodule
